// File: rtl/prompt_sequencer_if.sv
// Bundle of game-side and checker-side signals around the prompt sequencer.
// master: the sequencer (drives en/val and the score display outputs).
// slave : the game FSM / button checker (drives start, done, correct).
interface prompt_sequencer_if;
   logic       start;
   logic       done;
   logic       correct;
   logic       en;
   logic [2:0] val;
   logic [7:0] score;
   logic [3:0] strikes;
   logic [7:0] round;
   logic       last_hit;
   logic       result_vld;
   logic       busy;
   logic       game_over;

   modport master (
      input  start, done, correct,
      output en, val, score, strikes, round, last_hit, result_vld, busy, game_over
   );

   modport slave (
      output start, done, correct,
      input  en, val, score, strikes, round, last_hit, result_vld, busy, game_over
   );
endinterface

// File: rtl/prompt_sequencer.sv
// Purpose: issues pseudo-random button prompts to the checker, retires each answer, keeps score.
// Latency: start -> en high 3 cycles; checker done low -> result_vld 1 cycle (registered).
// Backpressure: holds in RETIRE while done stays high; per-prompt timeout forces a miss.
// Ports: clk, rst (sync, active-high); bus (master modport): start/done/correct in,
//        en/val to checker, score/strikes/round/last_hit/result_vld/busy/game_over to display.
// Optional: define PROMPT_SPEEDUP_EN to shrink the timeout by TIMEOUT_CYC/16 per hit (floor TIMEOUT_CYC/4).
module prompt_sequencer #(
   parameter int         ROUNDS      = 16,
   parameter int         MAX_STRIKES = 3,
   parameter int         TIMEOUT_CYC = 50000000,
   parameter int         GAP_CYC     = 25000000,
   parameter int         CNT_W       = 26,
   parameter logic [7:0] SEED        = 8'hA5
) (
   input  logic                clk,
   input  logic                rst,
   prompt_sequencer_if.master  bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_GEN, S_ISSUE, S_WAIT, S_RETIRE, S_GAP, S_OVER
   } state_t;

   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [3:0]       STRIKE_LIM = 4'(MAX_STRIKES);
   localparam logic [7:0]       ROUND_LIM  = 8'(ROUNDS);

   state_t           r_state, w_state_nxt;
   logic [7:0]       r_lfsr;
   logic [CNT_W-1:0] r_cnt;
   logic             r_hit;        // sticky hit flag in WAIT, then holds the prompt result
   logic             r_en;
   logic [2:0]       r_val;
   logic [7:0]       r_score;
   logic [3:0]       r_strikes;
   logic [7:0]       r_round;
   logic             r_last_hit;
   logic             r_result_vld;

   logic             w_fb;
   logic             w_start_game;
   logic             w_retire;
   logic             w_timeout;
   logic [CNT_W-1:0] w_to_last;
   logic [7:0]       w_score_nxt;
   logic [3:0]       w_strikes_nxt;

   assign w_fb          = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
   assign w_start_game  = ((r_state == S_IDLE) || (r_state == S_OVER)) && bus.start;
   assign w_retire      = (r_state == S_RETIRE) && !bus.done;
   assign w_timeout     = (r_cnt == w_to_last);
   assign w_score_nxt   = (r_hit && (r_score != 8'hFF)) ? r_score + 8'd1 : r_score;
   assign w_strikes_nxt = (!r_hit && (r_strikes != 4'hF)) ? r_strikes + 4'd1 : r_strikes;

`ifdef PROMPT_SPEEDUP_EN
   localparam logic [CNT_W-1:0] TO_FULL  = CNT_W'(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] TO_STEP  = CNT_W'(TIMEOUT_CYC / 16);
   localparam logic [CNT_W-1:0] TO_FLOOR = CNT_W'(TIMEOUT_CYC / 4);

   logic [CNT_W-1:0] r_timeout;

   assign w_to_last = r_timeout - CNT_ONE;

   always_ff @(posedge clk) begin
      if (rst || w_start_game) begin
         r_timeout <= TO_FULL;
      end else if (w_retire && r_hit) begin
         r_timeout <= (r_timeout >= TO_FLOOR + TO_STEP) ? r_timeout - TO_STEP : TO_FLOOR;
      end
   end
`else
   assign w_to_last = CNT_W'(TIMEOUT_CYC - 1);
`endif

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE, S_OVER: if (bus.start) w_state_nxt = S_GEN;
         S_GEN:          w_state_nxt = S_ISSUE;
         S_ISSUE:        w_state_nxt = S_WAIT;
         S_WAIT:         if (bus.done || w_timeout) w_state_nxt = S_RETIRE;
         S_RETIRE: begin
            if (!bus.done) begin
               if ((w_strikes_nxt >= STRIKE_LIM) || (r_round == ROUND_LIM)) w_state_nxt = S_OVER;
               else                                                         w_state_nxt = S_GAP;
            end
         end
         S_GAP:          if (r_cnt == GAP_LAST) w_state_nxt = S_GEN;
         default:        w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_lfsr       <= SEED;
         r_cnt        <= '0;
         r_hit        <= 1'b0;
         r_en         <= 1'b0;
         r_val        <= 3'd0;
         r_score      <= 8'd0;
         r_strikes    <= 4'd0;
         r_round      <= 8'd0;
         r_last_hit   <= 1'b0;
         r_result_vld <= 1'b0;
      end else begin
         r_lfsr       <= {r_lfsr[6:0], w_fb};
         r_result_vld <= 1'b0;
         case (r_state)
            S_IDLE, S_OVER: begin
               if (bus.start) begin
                  r_score    <= 8'd0;
                  r_strikes  <= 4'd0;
                  r_round    <= 8'd0;
                  r_last_hit <= 1'b0;
               end
            end
            S_GEN: begin
               // Code 0 is not a button, so it folds onto A.
               r_val   <= (r_lfsr[2:0] == 3'd0) ? 3'd1 : r_lfsr[2:0];
               r_round <= (r_round != 8'hFF) ? r_round + 8'd1 : r_round;
               r_cnt   <= '0;
               r_hit   <= 1'b0;
            end
            S_ISSUE: r_en <= 1'b1;
            S_WAIT: begin
               r_cnt <= r_cnt + CNT_ONE;
               if (bus.correct) r_hit <= 1'b1;
               // done wins over a coincident timeout; correct in the done cycle still counts.
               if (bus.done) begin
                  r_hit <= r_hit | bus.correct;
                  r_en  <= 1'b0;
               end else if (w_timeout) begin
                  r_hit <= 1'b0;
                  r_en  <= 1'b0;
               end
            end
            S_RETIRE: begin
               if (!bus.done) begin
                  r_result_vld <= 1'b1;
                  r_last_hit   <= r_hit;
                  r_score      <= w_score_nxt;
                  r_strikes    <= w_strikes_nxt;
                  r_cnt        <= '0;
               end
            end
            S_GAP:   r_cnt <= r_cnt + CNT_ONE;
            default: r_en  <= 1'b0;
         endcase
      end
   end

   assign bus.en         = r_en;
   assign bus.val        = r_val;
   assign bus.score      = r_score;
   assign bus.strikes    = r_strikes;
   assign bus.round      = r_round;
   assign bus.last_hit   = r_last_hit;
   assign bus.result_vld = r_result_vld;
   assign bus.busy       = (r_state != S_IDLE) && (r_state != S_OVER);
   assign bus.game_over  = (r_state == S_OVER);

endmodule

// File: tb/tb_prompt_sequencer.sv
// Bench for prompt_sequencer: a checker model answers each prompt in a chosen way and pushes
// the expected retire record; a negedge monitor pops and compares on every result_vld and
// tracks val against an independent LFSR model whenever en is high.
module tb_prompt_sequencer;
   localparam int ROUNDS = 4;
   localparam int MS     = 3;
`ifdef PROMPT_SPEEDUP_EN
   localparam int TO     = 64;
`else
   localparam int TO     = 20;
`endif
   localparam int GAP    = 5;

   localparam int M_HIT    = 0;
   localparam int M_TO     = 1;
   localparam int M_NOCORR = 2;
   localparam int M_SAME   = 3;

   typedef struct packed {
      logic       hit;
      logic [7:0] score;
      logic [3:0] strikes;
      logic [7:0] round;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   prompt_sequencer_if bus();

   prompt_sequencer #(
      .ROUNDS(ROUNDS), .MAX_STRIKES(MS), .TIMEOUT_CYC(TO), .GAP_CYC(GAP),
      .CNT_W(8), .SEED(8'hA5)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   always #5 clk = ~clk;

   int   n_cmp = 0;
   int   n_err = 0;
   exp_t q[$];

   int   m_score, m_strikes, m_round, g_hits;

   logic [7:0] m0, m1, m2;
   logic       mon_prev_en;
   logic [2:0] mon_val;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

   function automatic int exp_to(input int hits);
      int t;
      t = TO - hits * (TO / 16);
      if (t < TO / 4) t = TO / 4;
`ifndef PROMPT_SPEEDUP_EN
      t = TO;
`endif
      return t;
   endfunction

   // Independent LFSR model; m2 is the value the DUT sampled in GEN once en is seen high.
   always @(posedge clk) begin
      if (rst) begin
         m0 <= 8'hA5; m1 <= 8'hA5; m2 <= 8'hA5;
      end else begin
         m2 <= m1; m1 <= m0; m0 <= lfsr_next(m0);
      end
   end

   // Monitor
   always @(negedge clk) begin
      logic [2:0] ev;
      exp_t       e;
      if (rst) begin
         mon_prev_en = 1'b0;
      end else begin
         if (bus.en) begin
            if (!mon_prev_en) begin
               ev = (m2[2:0] == 3'd0) ? 3'd1 : m2[2:0];
               check("val_at_en_rise", 32'(bus.val), 32'(ev));
               mon_val = bus.val;
            end else begin
               check("val_stable", 32'(bus.val), 32'(mon_val));
            end
         end
         if (bus.result_vld) begin
            if (q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL unexpected_result_vld: got pulse, expected none (t=%0t)", $time);
            end else begin
               e = q.pop_front();
               check("retire_record", 32'({bus.last_hit, bus.score, bus.strikes, bus.round}), 32'(e));
            end
         end
         mon_prev_en = bus.en;
      end
   end

   task automatic new_game();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      m_score = 0; m_strikes = 0; m_round = 0; g_hits = 0;
   endtask

   task automatic wait_en(output bit ok);
      int w = 0;
      while (!bus.en && w < 100) begin @(negedge clk); w++; end
      ok = bus.en;
      if (!ok) begin
         n_cmp++; n_err++;
         $display("FAIL en_rise_wait: got en=0 after %0d cycles, expected en=1", w);
      end
   endtask

   task automatic run_prompt(input int mode, input int hold, input bit poke_start);
      int   idx;
      int   to;
      bit   ok;
      bit   hit;
      exp_t e;
      wait_en(ok);
      if (!ok) return;
      to  = exp_to(g_hits);
      m_round = (m_round < 255) ? m_round + 1 : 255;
      idx = 0;
      while (bus.en && idx < 300) begin
         bus.correct = ((mode == M_HIT) || (mode == M_SAME)) && (idx == 2);
         bus.start   = poke_start && (idx == 1);
         if ((mode == M_HIT) && (idx == 3))    bus.done = 1'b1;
         if ((mode == M_NOCORR) && (idx == 2)) bus.done = 1'b1;
         if ((mode == M_SAME) && (idx == to - 1)) bus.done = 1'b1;
         @(negedge clk);
         idx++;
      end
      bus.correct = 1'b0;
      bus.start   = 1'b0;
      if ((mode == M_TO) || (mode == M_SAME)) check("en_high_len", 32'(idx), 32'(to));
      hit = (mode == M_HIT) || (mode == M_SAME);
      if (hit) begin
         m_score = (m_score < 255) ? m_score + 1 : 255;
         g_hits++;
      end else begin
         m_strikes = (m_strikes < 15) ? m_strikes + 1 : 15;
      end
      e.hit = hit; e.score = 8'(m_score); e.strikes = 4'(m_strikes); e.round = 8'(m_round);
      q.push_back(e);
      for (int h = 0; h < hold; h++) begin
         check("retire_hold_quiet", 32'({bus.result_vld, bus.en}), 32'd0);
         @(negedge clk);
      end
      bus.done = 1'b0;
   endtask

   task automatic check_over(input string name, input int sc, input int st, input int rd);
      int w = 0;
      while (!bus.game_over && w < 20) begin @(negedge clk); w++; end
      check({name, "_over"}, 32'({bus.game_over, bus.busy, bus.en}), 32'b100);
      check({name, "_totals"}, 32'({bus.score, bus.strikes, bus.round}), 32'({8'(sc), 4'(st), 8'(rd)}));
   endtask

   task automatic check_reset(input string name);
      check(name, 32'({bus.en, bus.val, bus.score, bus.strikes, bus.round, bus.last_hit,
                       bus.result_vld, bus.busy, bus.game_over}), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int  c;
      bit  ok;
      bus.start = 1'b0; bus.done = 1'b0; bus.correct = 1'b0;
      repeat (3) @(negedge clk);
      check_reset("reset_state");
      rst = 1'b0;
      @(negedge clk);

      // Game 1: four clean hits; a start pulse mid-WAIT of prompt 2 must be ignored.
      new_game();
      run_prompt(M_HIT, 0, 1'b0);
      run_prompt(M_HIT, 0, 1'b1);
      run_prompt(M_HIT, 0, 1'b0);
      run_prompt(M_HIT, 0, 1'b0);
      check_over("game1", 4, 0, 4);

      // Game 2 (restart from OVER): checker never answers.
      new_game();
      run_prompt(M_TO, 0, 1'b0);
      run_prompt(M_TO, 0, 1'b0);
      run_prompt(M_TO, 0, 1'b0);
      check_over("game2", 0, 3, 3);

      // Game 3: done without correct, done on the timeout cycle, long done hold.
      new_game();
      run_prompt(M_NOCORR, 0, 1'b0);
      run_prompt(M_SAME, 0, 1'b0);
      run_prompt(M_HIT, 10, 1'b0);
      @(negedge clk);
      check("result_vld_after_release", 32'(bus.result_vld), 32'd1);
      c = 0;
      while (!bus.en && c < 50) begin @(negedge clk); c++; end
      check("gap_to_next_en", 32'(c), 32'(GAP + 2));
      run_prompt(M_HIT, 0, 1'b0);
      check_over("game3", 3, 1, 4);

      // Game 4: two hits then a timeout (shortened when the speedup is built), then reset mid-WAIT.
      new_game();
      run_prompt(M_HIT, 0, 1'b0);
      run_prompt(M_HIT, 0, 1'b0);
      run_prompt(M_TO, 0, 1'b0);
      wait_en(ok);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      q.delete();
      check_reset("reset_mid_wait");
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_after_reset", 32'({bus.busy, bus.en, bus.game_over}), 32'd0);

      check("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
